// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared types and constants for the PS/2 keyboard front end
// Contents: frame FSM state enum, frame bit constants, default parameter values.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } ps2_state_t;

  localparam int   PS2_DATA_BITS = 8;
  localparam logic PS2_START     = 1'b0;
  localparam logic PS2_STOP      = 1'b1;

  localparam int DEF_FIFO_DEPTH     = 8;
  localparam int DEF_FILTER_LEN     = 8;
  localparam int DEF_TIMEOUT_CYCLES = 50000;

endpackage

// File: rtl/ps2_glitch_filter.sv
// rtl/ps2_glitch_filter.sv - pin synchronizers and ps2_clk stability filter
// Ports:
//   clk, reset_n        system clock, async active-low reset
//   ps2_clk, ps2_data   raw asynchronous keyboard pins
//   data_sync           ps2_data after the 2-FF synchronizer
//   clk_filt            filtered ps2_clk level (resets to 1)
//   clk_fall            one-cycle pulse in the cycle the filtered clock drops
module ps2_glitch_filter
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = DEF_FILTER_LEN
) (
  input  logic clk,
  input  logic reset_n,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic data_sync,
  output logic clk_filt,
  output logic clk_fall
);

  localparam int             CW       = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(FILTER_LEN - 1);

  logic          clk_s1, clk_s2;
  logic          data_s1, data_s2;
  logic          filt_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_s1  <= 1'b1;
      clk_s2  <= 1'b1;
      data_s1 <= 1'b1;
      data_s2 <= 1'b1;
      filt_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      clk_s1  <= ps2_clk;
      clk_s2  <= clk_s1;
      data_s1 <= ps2_data;
      data_s2 <= data_s1;
      // The filtered level follows only after FILTER_LEN consecutive
      // disagreeing samples; any agreeing sample restarts the count.
      if (clk_s2 != filt_q) begin
        if (cnt_q == CNT_LAST) begin
          filt_q <= clk_s2;
          cnt_q  <= '0;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  // Asserted in the cycle whose closing edge flips the filter to 0, so the
  // data synchronizer output is sampled alongside it.
  assign clk_fall  = filt_q & ~clk_s2 & (cnt_q == CNT_LAST);
  assign clk_filt  = filt_q;
  assign data_sync = data_s2;

endmodule

// File: rtl/ps2_key_fifo.sv
// rtl/ps2_key_fifo.sv - PS/2 frame deserializer with show-ahead scan-code FIFO
// Ports:
//   clk, reset_n        system clock, async active-low reset
//   ps2_clk, ps2_data   raw keyboard pins
//   ps2_rd              one-cycle pop strobe
//   err_clr             clears overflow and frame_err
//   key                 FIFO head code, 0 when empty
//   ps2_ready           FIFO non-empty
//   overflow            sticky: valid code dropped on a full FIFO
//   frame_err           sticky: bad stop, bad parity or timeout
//   key_d               last four valid codes, newest in [7:0]
module ps2_key_fifo
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = DEF_FIFO_DEPTH,
  parameter int FILTER_LEN     = DEF_FILTER_LEN,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  input  logic        ps2_rd,
  input  logic        err_clr,
  output logic [7:0]  key,
  output logic        ps2_ready,
  output logic        overflow,
  output logic        frame_err,
  output logic [31:0] key_d
);

  localparam int          AW        = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT  = (AW + 1)'(FIFO_DEPTH);
  localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES);
  localparam logic [2:0]  LAST_BIT  = 3'(PS2_DATA_BITS - 1);

  logic data_sync, clk_filt, sample;

  ps2_glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
    .clk       (clk),
    .reset_n   (reset_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .data_sync (data_sync),
    .clk_filt  (clk_filt),
    .clk_fall  (sample)
  );

  // ---------------- frame FSM ----------------
  ps2_state_t  state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        par_q, par_d;
  logic [15:0] tmo_q, tmo_d;
  logic        push, ferr_set;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      tmo_q     <= tmo_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    tmo_d     = tmo_q;
    push      = 1'b0;
    ferr_set  = 1'b0;
    if (state_q != ST_IDLE && tmo_q == TMO_LIMIT) begin
      // Keyboard stalled mid-frame: drop the partial code.
      state_d  = ST_IDLE;
      tmo_d    = '0;
      ferr_set = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          tmo_d = '0;
          if (sample && data_sync == PS2_START) begin
            bit_cnt_d = '0;
            state_d   = ST_DATA;
          end
        end
        ST_DATA: begin
          if (sample) begin
            tmo_d     = '0;
            shift_d   = {data_sync, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == LAST_BIT) state_d = ST_PARITY;
          end else begin
            tmo_d = tmo_q + 16'd1;
          end
        end
        ST_PARITY: begin
          if (sample) begin
            tmo_d   = '0;
            par_d   = data_sync;
            state_d = ST_STOP;
          end else begin
            tmo_d = tmo_q + 16'd1;
          end
        end
        ST_STOP: begin
          if (sample) begin
            tmo_d   = '0;
            state_d = ST_IDLE;
            // Odd parity: data bits plus parity bit hold an odd number of ones.
            if (data_sync == PS2_STOP && (^{shift_q, par_q})) push = 1'b1;
            else                                              ferr_set = 1'b1;
          end else begin
            tmo_d = tmo_q + 16'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // ---------------- FIFO ----------------
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          empty, full, do_pop, do_push, ovf_set;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_CNT);
  assign do_pop  = ps2_rd & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push = push & (~full | do_pop);
  assign ovf_set = push & full & ~do_pop;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= shift_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
      key_d     <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW + 1)'(1);
        2'b01:   count_q <= count_q - (AW + 1)'(1);
        default: count_q <= count_q;
      endcase
      if (push) key_d <= {key_d[23:0], shift_q};
      // New errors take priority over a same-cycle clear.
      if (ovf_set)      overflow <= 1'b1;
      else if (err_clr) overflow <= 1'b0;
      if (ferr_set)     frame_err <= 1'b1;
      else if (err_clr) frame_err <= 1'b0;
    end
  end

  assign ps2_ready = ~empty;
  assign key       = empty ? 8'h00 : mem[rd_ptr_q];

endmodule

// File: tb/tb_ps2_key_fifo.sv
// tb/tb_ps2_key_fifo.sv - self-checking bench for ps2_key_fifo
module tb_ps2_key_fifo;

  localparam int HALF = 40;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic        ps2_rd = 1'b0;
  logic        err_clr = 1'b0;
  logic [7:0]  key;
  logic        ps2_ready;
  logic        overflow;
  logic        frame_err;
  logic [31:0] key_d;

  int passed = 0;
  int total  = 0;

  ps2_key_fifo #(
    .FIFO_DEPTH     (8),
    .FILTER_LEN     (4),
    .TIMEOUT_CYCLES (1000)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .ps2_rd    (ps2_rd),
    .err_clr   (err_clr),
    .key       (key),
    .ps2_ready (ps2_ready),
    .overflow  (overflow),
    .frame_err (frame_err),
    .key_d     (key_d)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  code;
    bit          bad_par;
    bit          bad_stop;
    bit          clr_before;
    int          pops;
    logic        exp_ready;
    logic [7:0]  exp_key;
    logic [31:0] exp_key_d;
    logic        exp_ferr;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Sends the first nbits bits of a frame; rd_at_stop raises ps2_rd in the
  // cycle of the stop-bit sample event (2 sync + FILTER_LEN-1 cycles after the fall).
  task automatic send_frame(input logic [7:0] code, input bit bad_par, input bit bad_stop,
                            input bit rd_at_stop, input int nbits);
    logic [10:0] bits;
    bits[0]    = 1'b0;
    bits[8:1]  = code;
    bits[9]    = (~^code) ^ bad_par;
    bits[10]   = ~bad_stop;
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk) ps2_data = bits[i];
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      if (rd_at_stop && i == 10) begin
        repeat (5) @(posedge clk);
        @(negedge clk) ps2_rd = 1'b1;
        @(negedge clk) ps2_rd = 1'b0;
        repeat (HALF - 7) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      ps2_clk = 1'b1;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic pop();
    @(negedge clk) ps2_rd = 1'b1;
    @(negedge clk) ps2_rd = 1'b0;
  endtask

  task automatic clear_err();
    @(negedge clk) err_clr = 1'b1;
    @(negedge clk) err_clr = 1'b0;
  endtask

  initial begin
    //            code   bpar  bstop clr  pops rdy key    key_d          ferr
    vecs[0] = '{8'hF0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 8'hF0, 32'h00001CF0, 1'b0};
    vecs[1] = '{8'h1C, 1'b0, 1'b0, 1'b0, 1, 1'b1, 8'h1C, 32'h001CF01C, 1'b0};
    vecs[2] = '{8'h1C, 1'b1, 1'b0, 1'b0, 0, 1'b1, 8'h1C, 32'h001CF01C, 1'b1};
    vecs[3] = '{8'h29, 1'b0, 1'b0, 1'b0, 1, 1'b1, 8'h29, 32'h1CF01C29, 1'b1};
    vecs[4] = '{8'h5A, 1'b0, 1'b1, 1'b1, 1, 1'b0, 8'h00, 32'h1CF01C29, 1'b1};

    repeat (3) @(negedge clk);
    check("reset_key", {24'h0, key}, 32'h0);
    check("reset_ready", {31'h0, ps2_ready}, 32'h0);
    check("reset_ovf", {31'h0, overflow}, 32'h0);
    check("reset_ferr", {31'h0, frame_err}, 32'h0);
    check("reset_key_d", key_d, 32'h0);
    @(negedge clk) reset_n = 1'b1;
    repeat (3) @(negedge clk);

    // Single code then pop
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0, 11);
    check("single_ready", {31'h0, ps2_ready}, 32'h1);
    check("single_key", {24'h0, key}, 32'h1C);
    check("single_key_d", key_d, 32'h0000001C);
    pop();
    check("single_pop_ready", {31'h0, ps2_ready}, 32'h0);
    check("single_pop_key", {24'h0, key}, 32'h0);
    pop();  // pop on empty must be ignored
    check("empty_pop_ready", {31'h0, ps2_ready}, 32'h0);

    // Table: break sequence, bad parity, sticky error, bad stop
    for (int v = 0; v < 5; v++) begin
      if (vecs[v].clr_before) begin
        clear_err();
        check($sformatf("vec%0d_clr", v), {31'h0, frame_err}, 32'h0);
      end
      send_frame(vecs[v].code, vecs[v].bad_par, vecs[v].bad_stop, 1'b0, 11);
      for (int p = 0; p < vecs[v].pops; p++) pop();
      check($sformatf("vec%0d_ready", v), {31'h0, ps2_ready}, {31'h0, vecs[v].exp_ready});
      check($sformatf("vec%0d_key", v), {24'h0, key}, {24'h0, vecs[v].exp_key});
      check($sformatf("vec%0d_key_d", v), key_d, vecs[v].exp_key_d);
      check($sformatf("vec%0d_ferr", v), {31'h0, frame_err}, {31'h0, vecs[v].exp_ferr});
    end
    clear_err();
    check("errclr_ferr", {31'h0, frame_err}, 32'h0);

    // Overflow: nine frames, no pops
    for (int i = 0; i < 9; i++) send_frame(8'h10 + 8'(i), 1'b0, 1'b0, 1'b0, 11);
    check("ovf_flag", {31'h0, overflow}, 32'h1);
    check("ovf_head", {24'h0, key}, 32'h10);
    check("ovf_key_d", key_d, 32'h15161718);
    clear_err();
    check("ovf_clr", {31'h0, overflow}, 32'h0);
    // Full FIFO with a pop in the push cycle
    send_frame(8'h40, 1'b0, 1'b0, 1'b1, 11);
    check("simul_ovf", {31'h0, overflow}, 32'h0);
    check("simul_key_d", key_d, 32'h16171840);
    for (int i = 0; i < 8; i++) begin
      logic [7:0] exp_k;
      exp_k = (i < 7) ? 8'h11 + 8'(i) : 8'h40;
      check($sformatf("drain%0d_key", i), {24'h0, key}, {24'h0, exp_k});
      check($sformatf("drain%0d_ready", i), {31'h0, ps2_ready}, 32'h1);
      pop();
    end
    check("drain_empty", {31'h0, ps2_ready}, 32'h0);

    // Timeout after four data bits
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 5);
    repeat (898) @(negedge clk);
    check("tmo_early", {31'h0, frame_err}, 32'h0);
    repeat (100) @(negedge clk);
    check("tmo_ferr", {31'h0, frame_err}, 32'h1);
    check("tmo_ready", {31'h0, ps2_ready}, 32'h0);
    clear_err();
    send_frame(8'h29, 1'b0, 1'b0, 1'b0, 11);
    check("tmo_next_key", {24'h0, key}, 32'h29);
    check("tmo_next_ferr", {31'h0, frame_err}, 32'h0);
    pop();

    // Short ps2_clk glitches with data low must not start a frame
    @(negedge clk) ps2_data = 1'b0;
    for (int g = 0; g < 6; g++) begin
      repeat (10) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (2) @(negedge clk);
      ps2_clk = 1'b1;
    end
    repeat (20) @(negedge clk);
    ps2_data = 1'b1;
    check("glitch_ready", {31'h0, ps2_ready}, 32'h0);
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0, 11);
    check("glitch_key", {24'h0, key}, 32'h1C);
    check("glitch_ferr", {31'h0, frame_err}, 32'h0);

    // Reset in the middle of a frame
    send_frame(8'hAA, 1'b0, 1'b0, 1'b0, 4);
    @(negedge clk) reset_n = 1'b0;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ready", {31'h0, ps2_ready}, 32'h0);
    check("rst_key", {24'h0, key}, 32'h0);
    check("rst_key_d", key_d, 32'h0);
    check("rst_ferr", {31'h0, frame_err}, 32'h0);
    @(negedge clk) reset_n = 1'b1;
    repeat (3) @(negedge clk);
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0, 11);
    check("rst_next_key", {24'h0, key}, 32'h1C);
    check("rst_next_key_d", key_d, 32'h0000001C);
    check("rst_next_ferr", {31'h0, frame_err}, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
